// File: rtl/i2c_target_if.sv
// -----------------------------------------------------------------------------
// i2c_target_if
//   Bundles the I2C pin-side and user-side signals of the i2c_target endpoint.
//   Signal names follow the original block's port list.
//
//   scl_in    SCL pin level (asynchronous to ref_clk)
//   sda_in    SDA pin level (asynchronous to ref_clk)
//   sda_oe    1 = pull SDA low, 0 = release (open drain)
//   rx_data   last byte written by the controller, valid with rx_valid
//   rx_valid  one-cycle pulse, rx_data updated in the same cycle
//   tx_data   byte to send on a read, sampled in the cycle tx_req is high
//   tx_req    one-cycle pulse requesting the next read byte
//   addressed high from own-address ACK until STOP / repeated START
//   rw        R/W bit of the current transaction (1 = read)
//
//   slave  : seen from the target block
//   master : seen from the pads / user logic / testbench
// -----------------------------------------------------------------------------
interface i2c_target_if;
    logic       scl_in;
    logic       sda_in;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_req;
    logic       addressed;
    logic       rw;

    modport slave (
        input  scl_in,
        input  sda_in,
        input  tx_data,
        output sda_oe,
        output rx_data,
        output rx_valid,
        output tx_req,
        output addressed,
        output rw
    );

    modport master (
        output scl_in,
        output sda_in,
        output tx_data,
        input  sda_oe,
        input  rx_data,
        input  rx_valid,
        input  tx_req,
        input  addressed,
        input  rw
    );
endinterface

// File: rtl/i2c_target.sv
// -----------------------------------------------------------------------------
// i2c_target
//   I2C target (slave) endpoint. SCL/SDA are oversampled on ref_clk through a
//   SYNC_STAGES flip-flop synchronizer plus one edge-detect register. START and
//   STOP are recognised in every state. A 7-bit address match is ACKed; written
//   bytes are delivered on rx_data/rx_valid and read bytes are requested with
//   tx_req and shifted out MSB first. SDA is open drain: the block only pulls
//   low through sda_oe.
//
//   Parameters
//     DEV_ADDR     7-bit address this target answers to
//     SYNC_STAGES  synchronizer depth on scl_in/sda_in (>= 2)
//
//   Ports
//     ref_clk  system clock, at least 8x the SCL frequency
//     rst      synchronous, active-high reset
//     bus      i2c_target_if.slave (pins + user byte interface)
// -----------------------------------------------------------------------------
module i2c_target #(
    parameter logic [6:0]  DEV_ADDR    = 7'h50,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic          ref_clk,
    input  logic          rst,
    i2c_target_if.slave   bus
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WRITE,
        ST_WRITE_ACK,
        ST_READ,
        ST_READ_ACK,
        ST_IGNORE
    } state_e;

    // ------------------------------------------------------------------
    // Input synchronizers and edge detection
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] scl_sync_q;
    logic [SYNC_STAGES-1:0] sda_sync_q;
    logic                   scl_prev_q;
    logic                   sda_prev_q;

    logic scl_s;
    logic sda_s;
    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det;

    // Synchronizers reset to the idle bus level (both lines high).
    always_ff @(posedge ref_clk) begin
        if (rst) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], bus.scl_in};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], bus.sda_in};
            scl_prev_q <= scl_sync_q[SYNC_STAGES-1];
            sda_prev_q <= sda_sync_q[SYNC_STAGES-1];
        end
    end

    assign scl_s     = scl_sync_q[SYNC_STAGES-1];
    assign sda_s     = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise  =  scl_s & ~scl_prev_q;
    assign scl_fall  = ~scl_s &  scl_prev_q;
    // SCL must be high on both samples so an SDA move is unambiguously framed.
    assign start_det =  scl_s & scl_prev_q &  sda_prev_q & ~sda_s;
    assign stop_det  =  scl_s & scl_prev_q & ~sda_prev_q &  sda_s;

    // ------------------------------------------------------------------
    // Protocol state
    // ------------------------------------------------------------------
    state_e     state_q,     state_d;
    logic [2:0] bit_cnt_q,   bit_cnt_d;
    logic [7:0] shift_q,     shift_d;
    logic       bit_seen_q,  bit_seen_d;
    logic       sda_oe_q,    sda_oe_d;
    logic [7:0] rx_data_q,   rx_data_d;
    logic       rx_valid_q,  rx_valid_d;
    logic       addressed_q, addressed_d;
    logic       rw_q,        rw_d;
    logic       mack_q,      mack_d;
    logic       tx_req_c;

    always_ff @(posedge ref_clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            bit_seen_q  <= 1'b0;
            sda_oe_q    <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            addressed_q <= 1'b0;
            rw_q        <= 1'b0;
            mack_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            bit_seen_q  <= bit_seen_d;
            sda_oe_q    <= sda_oe_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            addressed_q <= addressed_d;
            rw_q        <= rw_d;
            mack_q      <= mack_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        bit_seen_d  = bit_seen_q;
        sda_oe_d    = sda_oe_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        addressed_d = addressed_q;
        rw_d        = rw_q;
        mack_d      = mack_q;
        tx_req_c    = 1'b0;

        if (start_det) begin
            state_d     = ST_ADDR;
            bit_cnt_d   = '0;
            bit_seen_d  = 1'b0;
            sda_oe_d    = 1'b0;
            addressed_d = 1'b0;
        end else if (stop_det) begin
            state_d     = ST_IDLE;
            bit_cnt_d   = '0;
            bit_seen_d  = 1'b0;
            sda_oe_d    = 1'b0;
            addressed_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    sda_oe_d = 1'b0;
                end

                // The SCL fall that completes a START carries no data bit;
                // bit_seen_q makes only falls that follow a sampled rise count.
                ST_ADDR, ST_WRITE: begin
                    if (scl_rise) begin
                        shift_d    = {shift_q[6:0], sda_s};
                        bit_seen_d = 1'b1;
                    end else if (scl_fall && bit_seen_q) begin
                        bit_seen_d = 1'b0;
                        if (bit_cnt_q == 3'd7) begin
                            bit_cnt_d = '0;
                            if (state_q == ST_ADDR) begin
                                if (shift_q[7:1] == DEV_ADDR) begin
                                    state_d     = ST_ADDR_ACK;
                                    sda_oe_d    = 1'b1;
                                    rw_d        = shift_q[0];
                                    addressed_d = 1'b1;
                                end else begin
                                    state_d  = ST_IGNORE;
                                    sda_oe_d = 1'b0;
                                end
                            end else begin
                                state_d    = ST_WRITE_ACK;
                                rx_data_d  = shift_q;
                                rx_valid_d = 1'b1;
                                sda_oe_d   = 1'b1;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end
                end

                ST_ADDR_ACK: begin
                    if (scl_fall) begin
                        bit_cnt_d = '0;
                        if (rw_q) begin
                            state_d  = ST_READ;
                            tx_req_c = 1'b1;
                            shift_d  = bus.tx_data;
                            sda_oe_d = ~bus.tx_data[7];
                        end else begin
                            state_d  = ST_WRITE;
                            sda_oe_d = 1'b0;
                        end
                    end
                end

                ST_WRITE_ACK: begin
                    if (scl_fall) begin
                        state_d  = ST_WRITE;
                        sda_oe_d = 1'b0;
                    end
                end

                // shift_q[7] is the bit currently on the bus.
                ST_READ: begin
                    if (scl_fall) begin
                        if (bit_cnt_q == 3'd7) begin
                            bit_cnt_d = '0;
                            sda_oe_d  = 1'b0;
                            state_d   = ST_READ_ACK;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                            sda_oe_d  = ~shift_q[6];
                            shift_d   = {shift_q[6:0], 1'b0};
                        end
                    end
                end

                ST_READ_ACK: begin
                    if (scl_rise) begin
                        mack_d = sda_s;
                    end else if (scl_fall) begin
                        if (!mack_q) begin
                            state_d  = ST_READ;
                            tx_req_c = 1'b1;
                            shift_d  = bus.tx_data;
                            sda_oe_d = ~bus.tx_data[7];
                        end else begin
                            state_d  = ST_IGNORE;
                            sda_oe_d = 1'b0;
                        end
                    end
                end

                ST_IGNORE: begin
                    sda_oe_d = 1'b0;
                end

                default: begin
                    state_d  = ST_IDLE;
                    sda_oe_d = 1'b0;
                end
            endcase
        end
    end

    // tx_req is decoded combinationally so that tx_data is sampled in the very
    // cycle the request is visible; it is built from registered state only.
    assign bus.sda_oe    = sda_oe_q;
    assign bus.rx_data   = rx_data_q;
    assign bus.rx_valid  = rx_valid_q;
    assign bus.tx_req    = tx_req_c & ~rst;
    assign bus.addressed = addressed_q;
    assign bus.rw        = rw_q;

endmodule

// File: tb/tb_i2c_target.sv
// -----------------------------------------------------------------------------
// tb_i2c_target
//   Directed bench for i2c_target: a bit-banged controller drives SCL/SDA
//   through the open-drain bus model, and every expected value is hand-derived.
// -----------------------------------------------------------------------------
module tb_i2c_target;

    logic ref_clk = 1'b0;
    logic rst     = 1'b1;
    logic scl_drv = 1'b1;
    logic sda_drv = 1'b1;

    always #5 ref_clk = ~ref_clk;

    i2c_target_if bus ();

    // Open-drain wired-AND of controller and target.
    assign bus.scl_in = scl_drv;
    assign bus.sda_in = sda_drv & ~bus.sda_oe;

    i2c_target #(
        .DEV_ADDR    (7'h50),
        .SYNC_STAGES (2)
    ) dut (
        .ref_clk (ref_clk),
        .rst     (rst),
        .bus     (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Observers (sampled on the inactive edge).
    int       n_rxv      = 0;
    int       n_txr      = 0;
    int       n_oe_cyc   = 0;
    int       n_addr_cyc = 0;
    int       n_overlap  = 0;
    int       n_wide     = 0;
    logic     rxv_prev   = 1'b0;
    logic     txr_prev   = 1'b0;
    logic [7:0] rx_log [0:15];

    always @(negedge ref_clk) begin
        if (bus.rx_valid) begin
            if (n_rxv < 16) rx_log[n_rxv] = bus.rx_data;
            n_rxv++;
        end
        if (bus.tx_req)                 n_txr++;
        if (bus.sda_oe)                 n_oe_cyc++;
        if (bus.addressed)              n_addr_cyc++;
        if (bus.rx_valid && bus.tx_req) n_overlap++;
        if ((bus.rx_valid && rxv_prev) || (bus.tx_req && txr_prev)) n_wide++;
        rxv_prev = bus.rx_valid;
        txr_prev = bus.tx_req;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge ref_clk);
        #1;
    endtask

    // One SCL period starting and ending with SCL low; obs is the bus level
    // in the middle of the high phase.
    task automatic bit_slot(input logic b, output logic obs);
        sda_drv = b;
        wait_cyc(4);
        scl_drv = 1'b1;
        wait_cyc(4);
        obs = bus.sda_in;
        wait_cyc(4);
        scl_drv = 1'b0;
        wait_cyc(4);
    endtask

    task automatic i2c_start();
        sda_drv = 1'b1;
        wait_cyc(4);
        scl_drv = 1'b1;
        wait_cyc(8);
        sda_drv = 1'b0;
        wait_cyc(8);
        scl_drv = 1'b0;
        wait_cyc(4);
    endtask

    task automatic i2c_stop();
        sda_drv = 1'b0;
        wait_cyc(4);
        scl_drv = 1'b1;
        wait_cyc(8);
        sda_drv = 1'b1;
        wait_cyc(8);
    endtask

    // Controller writes a byte; ack is the bus level in the 9th slot (0 = ACK).
    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic o;
        for (int i = 7; i >= 0; i--) bit_slot(b[i], o);
        bit_slot(1'b1, ack);
    endtask

    // Controller reads a byte; next_tx is presented before the ACK slot so a
    // follow-on request picks it up.
    task automatic read_byte(input logic mack, input logic [7:0] next_tx,
                             output logic [7:0] data);
        logic o;
        data = '0;
        for (int i = 0; i < 8; i++) begin
            bit_slot(1'b1, o);
            data = {data[6:0], o};
        end
        bus.tx_data = next_tx;
        bit_slot(mack, o);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       ack;
        logic [7:0] rd;
        int         b_rxv, b_txr, b_oe, b_addr;

        bus.tx_data = 8'h00;

        // Reset state
        wait_cyc(4);
        check("rst_sda_oe",    {31'd0, bus.sda_oe},    32'd0);
        check("rst_rx_data",   {24'd0, bus.rx_data},   32'h00);
        check("rst_rx_valid",  {31'd0, bus.rx_valid},  32'd0);
        check("rst_tx_req",    {31'd0, bus.tx_req},    32'd0);
        check("rst_addressed", {31'd0, bus.addressed}, 32'd0);
        check("rst_rw",        {31'd0, bus.rw},        32'd0);
        rst = 1'b0;
        wait_cyc(8);

        // Write 0xA0 + 0x3C, 0xFF, STOP
        b_rxv = n_rxv;
        i2c_start();
        send_byte(8'hA0, ack);
        check("w1_addr_ack", {31'd0, ack}, 32'd0);
        check("w1_addressed", {31'd0, bus.addressed}, 32'd1);
        check("w1_rw", {31'd0, bus.rw}, 32'd0);
        send_byte(8'h3C, ack);
        check("w1_b0_ack", {31'd0, ack}, 32'd0);
        send_byte(8'hFF, ack);
        check("w1_b1_ack", {31'd0, ack}, 32'd0);
        check("w1_addr_before_stop", {31'd0, bus.addressed}, 32'd1);
        i2c_stop();
        check("w1_rxv_count", n_rxv - b_rxv, 32'd2);
        check("w1_rx0", {24'd0, rx_log[b_rxv]},     32'h3C);
        check("w1_rx1", {24'd0, rx_log[b_rxv + 1]}, 32'hFF);
        check("w1_rx_data", {24'd0, bus.rx_data}, 32'hFF);
        check("w1_addr_after_stop", {31'd0, bus.addressed}, 32'd0);

        // Foreign address 0x51 write
        b_rxv = n_rxv; b_oe = n_oe_cyc; b_addr = n_addr_cyc;
        i2c_start();
        send_byte(8'hA2, ack);
        check("na_addr_nack", {31'd0, ack}, 32'd1);
        send_byte(8'h77, ack);
        check("na_b0_nack", {31'd0, ack}, 32'd1);
        i2c_stop();
        check("na_oe_cycles", n_oe_cyc - b_oe, 32'd0);
        check("na_rxv_count", n_rxv - b_rxv, 32'd0);
        check("na_addr_cycles", n_addr_cyc - b_addr, 32'd0);

        // Read 0xA1: 0x96 (ACK), 0x5A (NACK)
        b_txr = n_txr;
        bus.tx_data = 8'h96;
        i2c_start();
        send_byte(8'hA1, ack);
        check("r_addr_ack", {31'd0, ack}, 32'd0);
        check("r_rw", {31'd0, bus.rw}, 32'd1);
        check("r_txreq_after_addr", n_txr - b_txr, 32'd1);
        read_byte(1'b0, 8'h5A, rd);
        check("r_byte0", {24'd0, rd}, 32'h96);
        read_byte(1'b1, 8'hEE, rd);
        check("r_byte1", {24'd0, rd}, 32'h5A);
        check("r_txreq_count", n_txr - b_txr, 32'd2);
        b_oe = n_oe_cyc; b_txr = n_txr;
        send_byte(8'h00, ack);
        check("r_ignore_nack", {31'd0, ack}, 32'd1);
        check("r_ignore_oe", n_oe_cyc - b_oe, 32'd0);
        check("r_ignore_txreq", n_txr - b_txr, 32'd0);
        i2c_stop();

        // Write 0x11, repeated START, read
        b_rxv = n_rxv;
        i2c_start();
        send_byte(8'hA0, ack);
        check("rs_w_addr_ack", {31'd0, ack}, 32'd0);
        check("rs_rw_write", {31'd0, bus.rw}, 32'd0);
        send_byte(8'h11, ack);
        check("rs_w_b0_ack", {31'd0, ack}, 32'd0);
        check("rs_rx0", {24'd0, rx_log[b_rxv]}, 32'h11);
        bus.tx_data = 8'h33;
        b_txr = n_txr;
        i2c_start();
        check("rs_addr_cleared", {31'd0, bus.addressed}, 32'd0);
        send_byte(8'hA1, ack);
        check("rs_r_addr_ack", {31'd0, ack}, 32'd0);
        check("rs_rw_read", {31'd0, bus.rw}, 32'd1);
        check("rs_txreq", n_txr - b_txr, 32'd1);
        read_byte(1'b1, 8'h00, rd);
        check("rs_r_byte0", {24'd0, rd}, 32'h33);
        i2c_stop();
        check("rs_rxv_count", n_rxv - b_rxv, 32'd1);

        // Reset while driving a 0 data bit in READ
        bus.tx_data = 8'h00;
        i2c_start();
        send_byte(8'hA1, ack);
        check("rr_addr_ack", {31'd0, ack}, 32'd0);
        check("rr_oe_driving", {31'd0, bus.sda_oe}, 32'd1);
        rst = 1'b1;
        wait_cyc(1);
        check("rr_oe_released", {31'd0, bus.sda_oe}, 32'd0);
        check("rr_addressed", {31'd0, bus.addressed}, 32'd0);
        rst = 1'b0;
        wait_cyc(4);
        b_rxv = n_rxv; b_txr = n_txr; b_oe = n_oe_cyc;
        send_byte(8'hA0, ack);
        check("rr_no_start_nack", {31'd0, ack}, 32'd1);
        i2c_stop();
        check("rr_oe_cycles", n_oe_cyc - b_oe, 32'd0);
        check("rr_pulses", (n_rxv - b_rxv) + (n_txr - b_txr), 32'd0);

        // STOP after 4 address bits, then a normal write
        b_rxv = n_rxv; b_txr = n_txr; b_oe = n_oe_cyc; b_addr = n_addr_cyc;
        i2c_start();
        bit_slot(1'b1, ack);
        bit_slot(1'b0, ack);
        bit_slot(1'b1, ack);
        bit_slot(1'b0, ack);
        i2c_stop();
        check("sp_oe_cycles", n_oe_cyc - b_oe, 32'd0);
        check("sp_pulses", (n_rxv - b_rxv) + (n_txr - b_txr), 32'd0);
        check("sp_addr_cycles", n_addr_cyc - b_addr, 32'd0);
        i2c_start();
        send_byte(8'hA0, ack);
        check("sp_addr_ack", {31'd0, ack}, 32'd0);
        send_byte(8'h42, ack);
        check("sp_b0_ack", {31'd0, ack}, 32'd0);
        i2c_stop();
        check("sp_rxv_count", n_rxv - b_rxv, 32'd1);
        check("sp_rx0", {24'd0, rx_log[b_rxv]}, 32'h42);

        // Pulse discipline over the whole run
        check("pulse_overlap", n_overlap, 32'd0);
        check("pulse_width", n_wide, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
